vram_cpu_arbiter: RTL and testbench

- Sequences 68000 accesses to VRAM1 (high byte) and VRAM2 (low byte) so they land only in the CPU-owned pixel slots of the tilemap fetch cycle.
- The tilemap generator drives the CPU address onto the VRAM bus while 2H=0. This block turns a CPU bus cycle into one slot-aligned write strobe or read capture, then returns DTACK.
- It sits between the CPU bus decode and VRAM1/VRAM2, alongside the tilemap generator.

---
 rtl/vram_cpu_arbiter.sv | 166 ++++++++++++++++
 tb/tb_vram_cpu_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_cpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_cpu_arbiter
// Description : Turns one 68000 bus cycle aimed at VRAM into a single
//               slot-aligned access. The write strobe or read capture is
//               placed in the CPU-owned pixel slots of the tilemap fetch
//               group (phases 0/1 and 4/5). DTACK is then returned after an
//               optional extra pixel delay.
// Ports       : i_EMU_MCLK          master clock
//               i_EMU_INITRST_n     synchronous active-low reset
//               i_EMU_CLK6MPCEN_n   6 MHz pixel enable (active low)
//               i_ABS_4H/2H/1H      pixel phase within the 8-pixel group
//               i_CPU_AS_n, i_VRAM_CS_n, i_CPU_RW, i_CPU_UDS_n, i_CPU_LDS_n
//                                   CPU bus cycle qualifiers
//               i_CPU_DIN           CPU write data
//               i_VRAM1_DOUT/2_DOUT VRAM read data (high / low byte)
//               o_VRAM_WRDATA       latched write data ([15:8] VRAM1)
//               o_VRAM1_WE_n/2_WE_n write strobes
//               o_CPU_DOUT          latched read data
//               o_CPU_DTACK_n       data acknowledge
//               o_BUSY              high whenever not idle
// Revision    : 1.0 - initial release
// ============================================================================
module vram_cpu_arbiter #(
  parameter int DTACK_DELAY = 0
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_INITRST_n,
  input  logic        i_EMU_CLK6MPCEN_n,
  input  logic        i_ABS_4H,
  input  logic        i_ABS_2H,
  input  logic        i_ABS_1H,
  input  logic        i_CPU_AS_n,
  input  logic        i_VRAM_CS_n,
  input  logic        i_CPU_RW,
  input  logic        i_CPU_UDS_n,
  input  logic        i_CPU_LDS_n,
  input  logic [15:0] i_CPU_DIN,
  input  logic [7:0]  i_VRAM1_DOUT,
  input  logic [7:0]  i_VRAM2_DOUT,
  output logic [15:0] o_VRAM_WRDATA,
  output logic        o_VRAM1_WE_n,
  output logic        o_VRAM2_WE_n,
  output logic [15:0] o_CPU_DOUT,
  output logic        o_CPU_DTACK_n,
  output logic        o_BUSY
);

  localparam logic [1:0] DELAY_INIT = 2'(DTACK_DELAY);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_STROBE = 3'd2,
    ST_DELAY  = 3'd3,
    ST_ACK    = 3'd4
  } state_t;

  state_t     state;
  logic       rw_lat;
  logic       uds_lat;
  logic       lds_lat;
  logic [1:0] delay_cnt;

  logic       tick;
  logic [2:0] phase;
  logic       req;
  logic       slot_start;

  assign tick  = ~i_EMU_CLK6MPCEN_n;
  assign phase = {i_ABS_4H, i_ABS_2H, i_ABS_1H};
  assign req   = ~i_CPU_AS_n & ~i_VRAM_CS_n;
  // Phases 0 and 4 open the two CPU slot pairs; the access then occupies
  // the following pixel (phase 1 or 5).
  assign slot_start = tick & (phase[1:0] == 2'b00);

  assign o_BUSY = (state != ST_IDLE);

  always_ff @(posedge i_EMU_MCLK) begin
    if (!i_EMU_INITRST_n) begin
      state         <= ST_IDLE;
      rw_lat        <= 1'b1;
      uds_lat       <= 1'b1;
      lds_lat       <= 1'b1;
      delay_cnt     <= 2'd0;
      o_VRAM_WRDATA <= 16'h0000;
      o_VRAM1_WE_n  <= 1'b1;
      o_VRAM2_WE_n  <= 1'b1;
      o_CPU_DOUT    <= 16'h0000;
      o_CPU_DTACK_n <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          // Sampled on every MCLK edge so a request is never missed between
          // pixel ticks.
          if (req) begin
            o_VRAM_WRDATA <= i_CPU_DIN;
            rw_lat        <= i_CPU_RW;
            uds_lat       <= i_CPU_UDS_n;
            lds_lat       <= i_CPU_LDS_n;
            state         <= ST_ARMED;
          end
        end

        ST_ARMED: begin
          if (i_CPU_AS_n) begin
            // Aborted before the slot came around: no VRAM side effect.
            state <= ST_IDLE;
          end else if (slot_start) begin
            if (!rw_lat) begin
              o_VRAM1_WE_n <= uds_lat;
              o_VRAM2_WE_n <= lds_lat;
            end
            state <= ST_STROBE;
          end
        end

        ST_STROBE: begin
          // AS_n is deliberately ignored here so a started strobe always
          // completes its full pixel.
          if (tick) begin
            o_VRAM1_WE_n <= 1'b1;
            o_VRAM2_WE_n <= 1'b1;
            if (rw_lat) begin
              o_CPU_DOUT <= {i_VRAM1_DOUT, i_VRAM2_DOUT};
            end
            if (DTACK_DELAY == 0) begin
              o_CPU_DTACK_n <= 1'b0;
              state         <= ST_ACK;
            end else begin
              delay_cnt <= DELAY_INIT;
              state     <= ST_DELAY;
            end
          end
        end

        ST_DELAY: begin
          if (tick) begin
            delay_cnt <= delay_cnt - 2'd1;
            if (delay_cnt == 2'd1) begin
              o_CPU_DTACK_n <= 1'b0;
              state         <= ST_ACK;
            end
          end
        end

        ST_ACK: begin
          // Leaving through IDLE forces one idle MCLK between accesses.
          if (i_CPU_AS_n) begin
            o_CPU_DTACK_n <= 1'b1;
            state         <= ST_IDLE;
          end
        end

        default: begin
          state         <= ST_IDLE;
          o_VRAM1_WE_n  <= 1'b1;
          o_VRAM2_WE_n  <= 1'b1;
          o_CPU_DTACK_n <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_cpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_cpu_arbiter
// Description : Self-checking bench for vram_cpu_arbiter. Two instances
//               (DTACK_DELAY 0 and 2) share one stimulus stream. Expected
//               timing is derived from the slot arithmetic of the pixel
//               schedule: a tick every 4 MCLKs, phase = tick count mod 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_cpu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen_n = 1'b1;
  logic        h4 = 1'b0, h2 = 1'b0, h1 = 1'b0;
  logic        as_n = 1'b1, cs_n = 1'b1, rw = 1'b1, uds_n = 1'b1, lds_n = 1'b1;
  logic [15:0] din = 16'h0;
  logic [7:0]  v1 = 8'h0, v2 = 8'h0;

  logic [15:0] wrd0, wrd2, dout0, dout2;
  logic        we1_0, we2_0, dt0, busy0;
  logic        we1_2, we2_2, dt2, busy2;

  always #5 clk = ~clk;

  vram_cpu_arbiter #(.DTACK_DELAY(0)) u_dut0 (
    .i_EMU_MCLK(clk), .i_EMU_INITRST_n(rst_n), .i_EMU_CLK6MPCEN_n(cen_n),
    .i_ABS_4H(h4), .i_ABS_2H(h2), .i_ABS_1H(h1),
    .i_CPU_AS_n(as_n), .i_VRAM_CS_n(cs_n), .i_CPU_RW(rw),
    .i_CPU_UDS_n(uds_n), .i_CPU_LDS_n(lds_n), .i_CPU_DIN(din),
    .i_VRAM1_DOUT(v1), .i_VRAM2_DOUT(v2),
    .o_VRAM_WRDATA(wrd0), .o_VRAM1_WE_n(we1_0), .o_VRAM2_WE_n(we2_0),
    .o_CPU_DOUT(dout0), .o_CPU_DTACK_n(dt0), .o_BUSY(busy0)
  );

  vram_cpu_arbiter #(.DTACK_DELAY(2)) u_dut2 (
    .i_EMU_MCLK(clk), .i_EMU_INITRST_n(rst_n), .i_EMU_CLK6MPCEN_n(cen_n),
    .i_ABS_4H(h4), .i_ABS_2H(h2), .i_ABS_1H(h1),
    .i_CPU_AS_n(as_n), .i_VRAM_CS_n(cs_n), .i_CPU_RW(rw),
    .i_CPU_UDS_n(uds_n), .i_CPU_LDS_n(lds_n), .i_CPU_DIN(din),
    .i_VRAM1_DOUT(v1), .i_VRAM2_DOUT(v2),
    .o_VRAM_WRDATA(wrd2), .o_VRAM1_WE_n(we1_2), .o_VRAM2_WE_n(we2_2),
    .o_CPU_DOUT(dout2), .o_CPU_DTACK_n(dt2), .o_BUSY(busy2)
  );

  int          cyc = 0;     // index of the next MCLK edge
  int          checks = 0;
  int          failures = 0;
  logic [15:0] dout_exp = 16'h0;

  typedef struct {
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [15:0] din;
    logic [7:0]  v1;
    logic [7:0]  v2;
    int          abort_len;   // 0 = complete; k = release AS k-1 edges before the slot edge
    int          wait_phase;  // -1 = start immediately
    int          exp_we1_len; // MCLKs VRAM1 strobe is low
    int          exp_we2_len;
    logic [15:0] exp_dout;    // o_CPU_DOUT after the transaction
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%h required=%h", name, cyc - 1, act, exp);
    end
  endtask

  // One MCLK: drive the pixel schedule for the coming edge, then sample 1ns after it.
  task automatic step();
    @(negedge clk);
    cen_n = !((cyc % 4) == 3);
    {h4, h2, h1} = 3'((cyc / 4) % 8);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // First tick edge after e0 whose phase is 0 or 4.
  function automatic int next_slot(input int e0);
    for (int n = e0 + 1; n < e0 + 64; n++)
      if ((n % 4) == 3 && ((n / 4) % 4) == 0) return n;
    return e0 + 64;
  endfunction

  task automatic check_all(input logic e_we1, input logic e_we2, input logic e_dt0,
                           input logic e_dt2, input logic e_busy, input logic [15:0] e_wrd);
    chk("we1_d0", 16'(we1_0), 16'(e_we1));
    chk("we2_d0", 16'(we2_0), 16'(e_we2));
    chk("we1_d2", 16'(we1_2), 16'(e_we1));
    chk("we2_d2", 16'(we2_2), 16'(e_we2));
    chk("dtack_d0", 16'(dt0), 16'(e_dt0));
    chk("dtack_d2", 16'(dt2), 16'(e_dt2));
    chk("busy_d0", 16'(busy0), 16'(e_busy));
    chk("busy_d2", 16'(busy2), 16'(e_busy));
    chk("wrdata_d0", wrd0, e_wrd);
    chk("wrdata_d2", wrd2, e_wrd);
    chk("dout_d0", dout0, dout_exp);
    chk("dout_d2", dout2, dout_exp);
  endtask

  task automatic do_txn(input vec_t v, output int we1_len, output int we2_len);
    int  e0, s, t, d0, d2, r, n;
    logic wr, ab;
    we1_len = 0;
    we2_len = 0;
    if (v.wait_phase >= 0)
      while (((cyc / 4) % 8) != v.wait_phase) step();
    rw = v.rw; uds_n = v.uds_n; lds_n = v.lds_n; din = v.din; v1 = v.v1; v2 = v.v2;
    as_n = 1'b0; cs_n = 1'b0;
    e0 = cyc;
    s  = next_slot(e0);
    t  = s + 4;
    d0 = t;
    d2 = t + 8;
    ab = (v.abort_len != 0);
    if (ab) begin
      r = s - (v.abort_len - 1);
      if (r < e0 + 1) r = e0 + 1;
    end else begin
      r = d2 + int'($urandom_range(1, 3));
    end
    wr = !v.rw && !ab;
    do begin
      if (cyc == r) begin
        as_n = 1'b1;
        cs_n = 1'b1;
      end
      step();
      n = cyc - 1;
      if (!ab && v.rw && n == t) dout_exp = {v.v1, v.v2};
      if (we1_0 == 1'b0) we1_len++;
      if (we2_0 == 1'b0) we2_len++;
      check_all(!(wr && !v.uds_n && n >= s && n < t),
                !(wr && !v.lds_n && n >= s && n < t),
                !(!ab && n >= d0 && n < r),
                !(!ab && n >= d2 && n < r),
                (n >= e0 && n < r),
                v.din);
    end while (n < r && n < e0 + 200);
  endtask

  vec_t tbl[7];
  int   l1, l2;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 16'hA55A, 8'h00, 8'h00, 0,  2, 4, 4, 16'h0000};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 16'h3C00, 8'h00, 8'h00, 0,  5, 4, 0, 16'h0000};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h12, 8'h34, 0,  0, 0, 0, 16'h1234};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 8'h55, 8'h66, 1,  6, 0, 0, 16'h1234};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h00C3, 8'h00, 8'h00, 0,  7, 0, 4, 16'h1234};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 16'h7777, 8'h00, 8'h00, 0,  1, 0, 0, 16'h1234};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 16'h0000, 8'hAB, 8'hCD, 0,  3, 0, 0, 16'hABCD};

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    check_all(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    rst_n = 1'b1;
    step();

    // Directed table
    foreach (tbl[i]) begin
      do_txn(tbl[i], l1, l2);
      chk("tbl_we1_len", 16'(l1), 16'(tbl[i].exp_we1_len));
      chk("tbl_we2_len", 16'(l2), 16'(tbl[i].exp_we2_len));
      chk("tbl_dout", dout0, tbl[i].exp_dout);
      step();
    end

    // Reset in the middle of a write strobe
    begin
      int s;
      rw = 1'b0; uds_n = 1'b0; lds_n = 1'b0; din = 16'h5AA5;
      as_n = 1'b0; cs_n = 1'b0;
      s = next_slot(cyc);
      while (cyc <= s) step();
      chk("pre_rst_we1", 16'(we1_0), 16'h0);
      chk("pre_rst_we2", 16'(we2_2), 16'h0);
      rst_n = 1'b0;
      step();
      dout_exp = 16'h0;
      check_all(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      rst_n = 1'b1; as_n = 1'b1; cs_n = 1'b1;
      step();
      do_txn('{1'b1, 1'b0, 1'b0, 16'h0, 8'h9E, 8'h21, 0, -1, 0, 0, 16'h9E21}, l1, l2);
      chk("post_rst_dout", dout2, 16'h9E21);
    end

    // Randomized transactions
    for (int k = 0; k < 40; k++) begin
      vec_t v;
      v.rw         = 1'($urandom_range(0, 1));
      v.uds_n      = 1'($urandom_range(0, 1));
      v.lds_n      = 1'($urandom_range(0, 1));
      v.din        = 16'($urandom);
      v.v1         = 8'($urandom);
      v.v2         = 8'($urandom);
      v.abort_len  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
      v.wait_phase = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 7));
      do_txn(v, l1, l2);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
